// File: rtl/keytr_multi_if.sv
// Key pins and per-channel debounce results between the raw board keys and keytr_multi.
interface keytr_multi_if #(
  parameter int unsigned N_KEYS = 4
) ();
  logic [N_KEYS-1:0] key;
  logic [N_KEYS-1:0] key_state;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] repeat_pulse;
  logic [N_KEYS-1:0] KEYON;

  modport master (output key, input key_state, press_pulse, release_pulse, repeat_pulse, KEYON);
  modport slave  (input key, output key_state, press_pulse, release_pulse, repeat_pulse, KEYON);
endinterface

// File: rtl/keytr_multi.sv
// N-channel key debouncer with press/release pulses and an active-low KEYON strobe.
// Auto-repeat pulses are built only when KEYTR_MULTI_AUTOREPEAT_EN is defined.
module keytr_multi #(
  parameter int unsigned N_KEYS      = 4,
  parameter int unsigned DEB_CYCLES  = 4096,
  parameter bit          KEY_ACT_LOW = 1'b1,
  parameter int unsigned REPEAT_DLY  = 500000,
  parameter int unsigned REPEAT_PER  = 100000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic          clock,
  input  logic          reset_n,
  keytr_multi_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  localparam logic [N_KEYS-1:0] REL_LVL  = {N_KEYS{KEY_ACT_LOW}};
  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  // Elaboration-time parameter sanity checks
  if (DEB_CYCLES < 2 || 64'(DEB_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_deb
    $error("keytr_multi: DEB_CYCLES out of range");
  end
  if (REPEAT_DLY < 1 || 64'(REPEAT_DLY) >= (64'd1 << CNT_W)) begin : g_bad_dly
    $error("keytr_multi: REPEAT_DLY out of range");
  end
  if (REPEAT_PER < 1 || 64'(REPEAT_PER) >= (64'd1 << CNT_W)) begin : g_bad_per
    $error("keytr_multi: REPEAT_PER out of range");
  end

`ifdef KEYTR_MULTI_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);
  logic [N_KEYS-1:0] phase;
`endif

  logic [N_KEYS-1:0]            sync1;
  logic [N_KEYS-1:0]            sync2;
  logic [N_KEYS-1:0]            p;
  state_t [N_KEYS-1:0]          state;
  logic [N_KEYS-1:0][CNT_W-1:0] cnt;
  logic [N_KEYS-1:0]            key_state_q;
  logic [N_KEYS-1:0]            press_q;
  logic [N_KEYS-1:0]            release_q;
  logic [N_KEYS-1:0]            repeat_q;
  logic [N_KEYS-1:0]            keyon_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign p = KEY_ACT_LOW ? ~sync2 : sync2;

  // Synchronizer, per-channel debounce FSMs and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1       <= REL_LVL;
      sync2       <= REL_LVL;
      key_state_q <= '0;
      press_q     <= '0;
      release_q   <= '0;
      repeat_q    <= '0;
      keyon_q     <= '1;
      cnt         <= '0;
`ifdef KEYTR_MULTI_AUTOREPEAT_EN
      phase       <= '0;
`endif
      for (int i = 0; i < int'(N_KEYS); i++) begin
        state[i] <= IDLE;
      end
    end else begin
      sync1     <= bus.key;
      sync2     <= sync1;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      keyon_q   <= ~press_q;
      for (int i = 0; i < int'(N_KEYS); i++) begin
        case (state[i])
          IDLE: begin
            if (p[i]) begin
              state[i] <= PRESS_DB;
              cnt[i]   <= CNT_W'(1);
            end else begin
              cnt[i]   <= '0;
            end
          end
          PRESS_DB: begin
            if (!p[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == DEB_LAST) begin
              state[i]       <= HELD;
              key_state_q[i] <= 1'b1;
              press_q[i]     <= 1'b1;
              cnt[i]         <= '0;
            end else begin
              cnt[i] <= sat_inc(cnt[i]);
            end
          end
          HELD: begin
            if (!p[i]) begin
              state[i] <= REL_DB;
              cnt[i]   <= CNT_W'(1);
`ifdef KEYTR_MULTI_AUTOREPEAT_EN
              phase[i] <= 1'b0;
`endif
            end else begin
`ifdef KEYTR_MULTI_AUTOREPEAT_EN
              // First repeat after REPEAT_DLY, then every REPEAT_PER while held
              if ((!phase[i] && cnt[i] == DLY_LAST) || (phase[i] && cnt[i] == PER_LAST)) begin
                repeat_q[i] <= 1'b1;
                cnt[i]      <= '0;
                phase[i]    <= 1'b1;
              end else begin
                cnt[i] <= sat_inc(cnt[i]);
              end
`else
              cnt[i] <= '0;
`endif
            end
          end
          REL_DB: begin
            if (p[i]) begin
              state[i] <= HELD;
              cnt[i]   <= '0;
            end else if (cnt[i] == DEB_LAST) begin
              state[i]       <= IDLE;
              key_state_q[i] <= 1'b0;
              release_q[i]   <= 1'b1;
              cnt[i]         <= '0;
            end else begin
              cnt[i] <= sat_inc(cnt[i]);
            end
          end
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.key_state     = key_state_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.repeat_pulse  = repeat_q;
  assign bus.KEYON         = keyon_q;

endmodule

// File: tb/tb_keytr_multi.sv
// Self-checking bench for keytr_multi: vector table plus a cycle-stamped pulse scoreboard.
module tb_keytr_multi;

  localparam int NK   = 4;
  localparam int DEB  = 4;
  localparam int RDLY = 10;
  localparam int RPER = 3;
  localparam int LAT  = DEB + 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  keytr_multi_if #(.N_KEYS(NK)) bus ();

  keytr_multi #(
    .N_KEYS(NK), .DEB_CYCLES(DEB), .KEY_ACT_LOW(1'b1),
    .REPEAT_DLY(RDLY), .REPEAT_PER(RPER), .CNT_W(20)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rep;
  } exp_t;

  typedef struct {
    logic [3:0] key;
    int         hold;
    logic [3:0] st;
    logic [3:0] press;
    logic [3:0] rel;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[$];
  int         cyc        = 0;
  int         total      = 0;
  int         bad        = 0;
  bit         mon_en     = 1'b0;
  logic [3:0] prev_press = 4'h0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Every cycle: pulses must match the scoreboard, KEYON must mirror last cycle's press
  always @(negedge clock) begin : mon
    exp_t       e;
    logic [3:0] ep, er, et, kexp;
    ep = 4'h0;
    er = 4'h0;
    et = 4'h0;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e  = sb.pop_front();
        ep = e.press;
        er = e.rel;
        et = e.rep;
      end
      kexp = ~prev_press;
      chk("press_pulse", bus.press_pulse, ep);
      chk("release_pulse", bus.release_pulse, er);
      chk("repeat_pulse", bus.repeat_pulse, et);
      chk("KEYON", bus.KEYON, kexp);
      prev_press = ep;
    end
  end

  initial begin
    int c0;
    bus.key = 4'hF;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_key_state", bus.key_state, 4'h0);
    chk("rst_press", bus.press_pulse, 4'h0);
    chk("rst_release", bus.release_pulse, 4'h0);
    chk("rst_repeat", bus.repeat_pulse, 4'h0);
    chk("rst_KEYON", bus.KEYON, 4'hF);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // key pattern, cycles held, key_state after, press/release expected LAT cycles later
    vecs.push_back('{4'hF, 10, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'hE, 10, 4'h1, 4'h1, 4'h0});
    vecs.push_back('{4'hF, 10, 4'h0, 4'h0, 4'h1});
    for (int b = 0; b < 5; b++) begin
      vecs.push_back('{4'hD, DEB - 1, 4'h0, 4'h0, 4'h0});
      vecs.push_back('{4'hF, DEB - 1, 4'h0, 4'h0, 4'h0});
    end
    vecs.push_back('{4'hF, 6, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'hE, 10, 4'h1, 4'h1, 4'h0});
    vecs.push_back('{4'hF, 2, 4'h1, 4'h0, 4'h0});
    vecs.push_back('{4'hE, 1, 4'h1, 4'h0, 4'h0});
    vecs.push_back('{4'hF, 10, 4'h0, 4'h0, 4'h1});
    vecs.push_back('{4'h3, 10, 4'hC, 4'hC, 4'h0});
    vecs.push_back('{4'hF, 10, 4'h0, 4'h0, 4'hC});

    @(negedge clock);
    foreach (vecs[i]) begin
      bus.key = vecs[i].key;
      if (vecs[i].press != 4'h0 || vecs[i].rel != 4'h0)
        sb.push_back('{cyc + LAT, vecs[i].press, vecs[i].rel, 4'h0});
      repeat (vecs[i].hold) @(negedge clock);
      chk($sformatf("vec%0d_key_state", i), bus.key_state, vecs[i].st);
    end

    // Long hold on key 0 for auto-repeat, then reset while held
    bus.key = 4'hE;
    c0 = cyc;
    sb.push_back('{c0 + LAT, 4'h1, 4'h0, 4'h0});
`ifdef KEYTR_MULTI_AUTOREPEAT_EN
    for (int k = RDLY; k <= 30; k += RPER)
      sb.push_back('{c0 + LAT + k, 4'h0, 4'h0, 4'h1});
`endif
    repeat (LAT + 30) @(negedge clock);
    chk("held_key_state", bus.key_state, 4'h1);
    reset_n = 1'b0;
    bus.key = 4'hF;
    repeat (3) @(negedge clock);
    chk("midrst_key_state", bus.key_state, 4'h0);
    chk("midrst_KEYON", bus.KEYON, 4'hF);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("postrst_key_state", bus.key_state, 4'h0);

    mon_en = 1'b0;
    while (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL missing_pulse cycle=%0d got=none want=press %h rel %h rep %h",
               sb[0].cyc, sb[0].press, sb[0].rel, sb[0].rep);
      void'(sb.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
